otter_intr_ctrl: RTL
====================

Name: otter_intr_ctrl

Overview:
- Interrupt front end for the OTTER core; sits directly upstream of the control-unit FSM and drives its `intr` input.
- Synchronises and debounces up to N_SRC asynchronous board-level interrupt lines, then turns each clean rising edge into a latched pending bit.
- Applies the per-source enables and the global mstatus.MIE gate, and presents one prioritised request plus its source ID.
- Clears the serviced pending bit when the control unit reports `intr_taken`.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=2).
- ID_W, $clog2(N_SRC) (minimum 1), width of the source ID.

Ports:
- clk  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- irq_in  in  N_SRC  raw asynchronous interrupt lines (buttons, peripherals).
- irq_en  in  N_SRC  per-source enable, from the CSR/MMIO enable register.
- mie  in  1  global interrupt enable, mstatus.MIE from the CSR file.
- intr_taken  in  1  one-cycle strobe from the control unit in its interrupt state.
- intr  out  1  interrupt request to the control unit.
- intr_id  out  ID_W  index of the highest-priority enabled pending source.
- pending  out  N_SRC  raw pending bits, for CSR/MMIO readback.

Behaviour:
- Reset (RST=1 at a rising edge):
  - Clears every synchroniser flop, debounce counter and pending bit.
  - Puts every debounce FSM in ST_LOW.
  - Outputs after reset: intr=0, intr_id=0, pending=0.
  - Reset mid-debounce discards the partial count.
  - A line still held high after reset is debounced again and produces exactly one event.
- Synchroniser: a 2-flop chain per source; all later logic uses only the second flop.
- Debounce FSM per source: states ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW.
  - ST_LOW: on sync=1, load the counter with 1 and go to ST_WAIT_HIGH.
  - ST_WAIT_HIGH:
    - sync=0: return to ST_LOW and clear the counter.
    - sync=1 and counter==DEBOUNCE_CYCLES-1: go to ST_HIGH and emit a one-cycle `rise` pulse.
    - otherwise increment the counter.
  - ST_HIGH: on sync=0, load the counter with 1 and go to ST_WAIT_LOW.
  - ST_WAIT_LOW: mirror of ST_WAIT_HIGH without a pulse.
    - sync=1: return to ST_HIGH.
    - DEBOUNCE_CYCLES consecutive lows: go to ST_LOW.
  - The counter is sized $clog2(DEBOUNCE_CYCLES+1) and never wraps.
- Latency: a clean high on irq_in that stays stable sets its pending bit DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high. Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Pending latch:
  - `rise` sets the bit.
  - The bit clears only when intr_taken=1 and the bit is the one selected by intr_id in that same cycle.
  - If set and clear hit the same bit in the same cycle, set wins; the new event is kept.
  - A second `rise` while the bit is already pending is absorbed (no counting).
- Request logic (combinational from registered state):
  - masked = pending & irq_en.
  - intr = mie & |masked.
  - intr_id = index of the lowest set bit of masked (index 0 has highest priority); intr_id=0 when masked=0.
- Gating:
  - With mie=0 or irq_en[i]=0, pending[i] is retained; intr rises in the cycle the gate opens.
  - intr_taken while intr=0 has no effect.
- Hold stability: intr_id stays stable while intr is asserted, until intr_taken, unless a higher-priority source becomes pending first. The control unit samples `intr` in its execute state, so a late higher-priority arrival is acceptable.

Decomposition:
- Package otter_intr_pkg holds:
  - the debounce state enum debounce_state_t {ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW};
  - the default constants DEF_N_SRC=4 and DEF_DEBOUNCE_CYCLES=16.
- Sub-module otter_debounce_one_shot: synchroniser, debounce FSM and counter for one line; outputs `rise`. Parameter DEBOUNCE_CYCLES; N_SRC instances are created with generate.
- The top level holds the pending register, priority encoder and gating.

Test Plan (N_SRC=4, DEBOUNCE_CYCLES=4):
- Assert RST for 2 cycles with irq_in=4'b0000 -> intr=0, intr_id=0, pending=0 on the first edge after RST falls.
- Hold irq_in[2]=1 with irq_en=4'b1111 and mie=1 -> pending=4'b0100 and intr=1 exactly 7 edges later, intr_id=2. Then one cycle of intr_taken -> pending=0 and intr=0 on the next edge.
- Apply a 3-cycle high pulse on irq_in[1] -> pending stays 0. Then a 4-cycle stable high -> pending[1]=1.
- Set irq_in[3] and irq_in[0] pending together -> intr_id=0. After intr_taken -> intr_id=3 and intr stays 1. After a second intr_taken -> intr=0.
- Hold mie=0 with pending=4'b0010 -> intr=0 and pending is held. Set mie=1 -> intr=1 in the same cycle, intr_id=1. Set irq_en[1]=0 -> intr=0 while pending[1] is still 1.
- Let a `rise` on source 0 coincide with intr_taken for source 0 -> pending[0] remains 1. Then assert RST mid-debounce of source 2 -> no pending[2] appears from the interrupted count.

Source files
------------

// File: rtl/otter_intr_pkg.sv
// rtl/otter_intr_pkg.sv - shared types and defaults for the OTTER interrupt front end
//
// Purpose: debounce FSM state type and default parameter values used by
//          otter_debounce_one_shot and otter_intr_ctrl.
// Ports:   none (package).
package otter_intr_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } debounce_state_t;

  localparam int DEF_N_SRC           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/otter_debounce_one_shot.sv
// rtl/otter_debounce_one_shot.sv - synchroniser, debouncer and rising-edge one-shot for one line
//
// Purpose: brings one asynchronous interrupt line into the clk domain, accepts a
//          level change only after DEBOUNCE_CYCLES consecutive stable samples,
//          and pulses `rise` for one cycle on each accepted low-to-high change.
// Ports:
//   clk     in   system clock
//   RST     in   synchronous active-high reset
//   irq_in  in   raw asynchronous interrupt line
//   rise    out  registered one-cycle pulse on a debounced rising edge
module otter_debounce_one_shot
  import otter_intr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic RST,
  input  logic irq_in,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  // The counter already holds 1 on entry to a WAIT state, so reaching
  // CNT_LAST while the level is still stable means DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_LOW;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      case (state)
        ST_LOW: begin
          if (sync2) begin
            cnt   <= CNT_W'(1);
            state <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync2) begin
            cnt   <= '0;
            state <= ST_LOW;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_HIGH;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync2) begin
            cnt   <= CNT_W'(1);
            state <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (sync2) begin
            cnt   <= '0;
            state <= ST_HIGH;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_LOW;
        end
      endcase
    end
  end

endmodule

// File: rtl/otter_intr_ctrl.sv
// rtl/otter_intr_ctrl.sv - interrupt front end driving the OTTER control unit intr input
//
// Purpose: debounces N_SRC interrupt lines, latches each debounced rising edge
//          as a pending bit, gates by per-source enable and mstatus.MIE, and
//          presents a fixed-priority request (source 0 highest).
// Ports:
//   clk         in   system clock
//   RST         in   synchronous active-high reset
//   irq_in      in   [N_SRC] raw asynchronous interrupt lines
//   irq_en      in   [N_SRC] per-source enables
//   mie         in   global interrupt enable (mstatus.MIE)
//   intr_taken  in   one-cycle strobe: the request shown this cycle is serviced
//   intr        out  interrupt request to the control unit
//   intr_id     out  [ID_W] index of the selected source
//   pending     out  [N_SRC] raw pending bits for readback
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int N_SRC           = DEF_N_SRC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ID_W            = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             mie,
  input  logic             intr_taken,
  output logic             intr,
  output logic [ID_W-1:0]  intr_id,
  output logic [N_SRC-1:0] pending
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] masked;
  logic [N_SRC-1:0] clr;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    otter_debounce_one_shot #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .RST   (RST),
      .irq_in(irq_in[g]),
      .rise  (rise[g])
    );
  end

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    masked  = pending & irq_en;
    intr    = mie & (|masked);
    intr_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) intr_id = ID_W'(i);
    end
  end

  // Only the source actually being presented can be acknowledged; a strobe
  // with no request showing is ignored.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = intr & intr_taken & (intr_id == ID_W'(i));
    end
  end

  // Set is ORed in after the clear so a fresh edge survives a same-cycle ack.
  always_ff @(posedge clk) begin
    if (RST) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

endmodule
